led_pattern_seq: RTL and testbench
==================================

// Module: led_pattern_seq
// PURPOSE
//   Parametrised LED pattern sequencer: WIDTH-bit output stepped at a programmable rate by
//   an internal tick prescaler. Four run-time modes: fill/drain, chase, bounce, blink.
//   Sits between the board clock and the LED pins; replaces the fixed-pattern
//   divider + shifter pair with one block that has speed, enable and mode control.
// PARAMETERS
//   WIDTH    8           LED count (>=2)
//   CLK_HZ   50_000_000  input clock frequency
//   STEP_HZ  1           base pattern step rate at SPEED=0; DIV = CLK_HZ/STEP_HZ (>=1)
// PORTS
//   CLK    in   1      system clock, rising edge
//   RST    in   1      asynchronous reset, active low
//   EN     in   1      1 = run, 0 = freeze (Q and prescaler hold)
//   MODE   in   2      0 FILL_DRAIN, 1 CHASE, 2 BOUNCE, 3 BLINK
//   SPEED  in   2      step period = DIV << SPEED clocks (x1, x2, x4, x8 slower)
//   Q      out  WIDTH  LED pattern, registered
//   STEP   out  1      1-clock pulse in the cycle Q takes a new pattern value
//   WRAP   out  1      1-clock pulse with the STEP that returns Q to the mode start value
// BEHAVIOUR
//   Reset (RST=0, async): Q=0, STEP=0, WRAP=0, prescaler=0, mode_q=FILL_DRAIN, dir=up, phase=fill.
//   Prescaler: cnt counts while EN=1; tick when cnt >= (DIV<<SPEED)-1, then cnt=0.
//     '>=' so a SPEED decrease with cnt above new terminal ticks next cycle, no rollover.
//     cnt width = clog2(DIV*8). EN=0: cnt holds, no tick.
//   Step latency: Q, STEP, WRAP register on the clock edge where tick is true.
//   Mode start values: FILL 0, CHASE 1, BOUNCE 1, BLINK 0.
//   Mode change: MODE registered into mode_q every clock; MODE != mode_q -> next edge loads
//     Q=start(MODE), cnt=0, dir=up, phase=fill, STEP=0, WRAP=0 (regardless of EN/tick).
//     Reload has priority over a coincident tick.
//   FILL_DRAIN (period 2*WIDTH): fill phase Q={Q[W-2:0],1} until all ones; drain phase
//     Q={Q[W-2:0],0} until zero. W=8: 00,01,03..FF,FE,FC..80,00. WRAP on step to 00.
//   CHASE (period WIDTH): Q rotate left by 1; WRAP on step to 01 (from MSB).
//   BOUNCE (period 2*WIDTH-2): one-hot; dir up shifts left, at MSB dir flips, down shifts
//     right, at bit0 dir flips. W=8: 01,02..80,40..02,01. WRAP on step to 01.
//   BLINK (period 2): Q = ~Q between 0 and all ones; WRAP on step to 0.
//   Q outside legal set (cannot occur post-reset): next step loads start value.
//   STEP/WRAP are 0 in every non-tick cycle; never asserted while EN=0.
// STRUCTURE
//   led_pattern_pkg: MODE_FILL/CHASE/BOUNCE/BLINK localparams (2-bit), mode_start()
//     function returning start value for a WIDTH, SPEED_W=2.
//   led_tick_gen: sub-module, prescaler (DIV, SPEED, EN -> tick); cleared by reload strobe.
//   led_pattern_seq: mode_q, reload detect, pattern register, dir/phase flags, STEP/WRAP.
// TESTING  (WIDTH=8, CLK_HZ=8, STEP_HZ=2 -> DIV=4)
//   Reset low mid-run, MODE=0 -> Q=00, STEP=WRAP=0 immediately, without clock edge.
//   FILL, SPEED=0, EN=1 -> STEP every 4 clks; Q=FF after 8 steps, 00 after 16 with WRAP=1.
//   BOUNCE -> Q 01,02..80,40..01 over 14 steps; WRAP only on step to 01.
//   SPEED 3 -> 0 with cnt=20 -> tick next clk, then STEP every 4 clks.
//   EN=0 for 50 clks during CHASE Q=10 -> Q holds 10, no STEP; EN=1 resumes remaining count.
//   MODE 1->3 coincident with tick -> Q=00, no STEP that cycle; first BLINK step Q=FF.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared mode encodings, flag types and the per-mode start value for the LED sequencer.
package led_pattern_pkg;

    localparam int SPEED_W = 2;
    localparam int START_W = 64;

    localparam logic [1:0] MODE_FILL   = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

    // Callers truncate to their own WIDTH; only bit 0 is ever set.
    function automatic logic [START_W-1:0] mode_start(input logic [1:0] mode);
        logic [START_W-1:0] v;
        v = '0;
        if (mode == MODE_CHASE || mode == MODE_BOUNCE) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: one-cycle tick every (DIV << speed) enabled clocks, cleared on reload.
module led_tick_gen
    import led_pattern_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    localparam int CW = $clog2(DIV * 8);

    logic [CW-1:0] cnt;
    logic [CW-1:0] term;

    always_comb begin
        term = CW'((DIV << speed) - 1);
    end

    // '>=' lets a speed decrease with cnt already past the new terminal tick at once.
    assign tick = en && !clr && (cnt >= term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: fill/drain, chase, bounce and blink patterns stepped by led_tick_gen.
module led_pattern_seq
    import led_pattern_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [1:0]         MODE,
    input  logic [SPEED_W-1:0] SPEED,
    output logic [WIDTH-1:0]   Q,
    output logic               STEP,
    output logic               WRAP
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [1:0]       mode_q;
    dir_t             dir, dir_n;
    phase_t           phase, phase_n;
    logic [WIDTH-1:0] q_n;
    logic             step_n, wrap_n;
    logic             tick, reload;
    logic [WIDTH-1:0] start_cur, start_new;
    logic             onehot, legal_fill, legal_drain;

    assign reload    = (MODE != mode_q);
    assign start_cur = WIDTH'(mode_start(mode_q));
    assign start_new = WIDTH'(mode_start(MODE));

    assign onehot      = (Q != '0) && ((Q & (Q - ONE)) == '0);
    assign legal_fill  = ((Q & (Q + ONE)) == '0) && (Q != ONES);
    assign legal_drain = ((~Q & (~Q + ONE)) == '0) && (Q != '0);

    led_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (CLK),
        .rst_n(RST),
        .en   (EN),
        .clr  (reload),
        .speed(SPEED),
        .tick (tick)
    );

    always_comb begin
        q_n     = Q;
        dir_n   = dir;
        phase_n = phase;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        if (reload) begin
            q_n     = start_new;
            dir_n   = DIR_UP;
            phase_n = PH_FILL;
        end else if (tick) begin
            step_n = 1'b1;
            // Any pattern outside the mode's legal set falls back to the start value.
            q_n     = start_cur;
            dir_n   = DIR_UP;
            phase_n = PH_FILL;
            case (mode_q)
                MODE_FILL: begin
                    if (phase == PH_FILL && legal_fill) begin
                        q_n     = {Q[WIDTH-2:0], 1'b1};
                        phase_n = ({Q[WIDTH-2:0], 1'b1} == ONES) ? PH_DRAIN : PH_FILL;
                    end else if (phase == PH_DRAIN && legal_drain) begin
                        q_n     = {Q[WIDTH-2:0], 1'b0};
                        phase_n = ({Q[WIDTH-2:0], 1'b0} == '0) ? PH_FILL : PH_DRAIN;
                    end
                end
                MODE_CHASE: begin
                    if (onehot) begin
                        q_n = {Q[WIDTH-2:0], Q[WIDTH-1]};
                    end
                end
                MODE_BOUNCE: begin
                    if (onehot) begin
                        // Direction flips at each end and the move goes the other way.
                        if (dir == DIR_UP) begin
                            q_n   = Q[WIDTH-1] ? (Q >> 1) : (Q << 1);
                            dir_n = Q[WIDTH-1] ? DIR_DOWN : DIR_UP;
                        end else begin
                            q_n   = Q[0] ? (Q << 1) : (Q >> 1);
                            dir_n = Q[0] ? DIR_UP : DIR_DOWN;
                        end
                    end
                end
                default: begin
                    if (Q == '0 || Q == ONES) begin
                        q_n = ~Q;
                    end
                end
            endcase
            wrap_n = (q_n == start_cur);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q <= MODE_FILL;
            Q      <= '0;
            STEP   <= 1'b0;
            WRAP   <= 1'b0;
            dir    <= DIR_UP;
            phase  <= PH_FILL;
        end else begin
            mode_q <= MODE;
            Q      <= q_n;
            STEP   <= step_n;
            WRAP   <= wrap_n;
            dir    <= dir_n;
            phase  <= phase_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (WIDTH=8, DIV=4) with an expected-step queue and monitor.
module tb_led_pattern_seq;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         EN = 1'b0;
    logic [1:0]   MODE = 2'd0;
    logic [1:0]   SPEED = 2'd0;
    logic [W-1:0] Q;
    logic         STEP;
    logic         WRAP;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_step = 0;

    // Entry: {gap[7:0], wrap, q[7:0]}; gap 0 means interval not checked.
    logic [16:0] exp_q[$];

    led_pattern_seq #(
        .WIDTH  (W),
        .CLK_HZ (8),
        .STEP_HZ(2)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .MODE (MODE),
        .SPEED(SPEED),
        .Q    (Q),
        .STEP (STEP),
        .WRAP (WRAP)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] q, input logic w, input logic [7:0] gap);
        exp_q.push_back({gap, w, q});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d steps still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every STEP pops one expected pattern and checks value, WRAP and interval.
    always @(negedge CLK) begin
        logic [16:0] it;
        if (RST && STEP) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_step: q=%0h wrap=%0b", Q, WRAP);
            end else begin
                it = exp_q.pop_front();
                check("step_wrap_q", 32'({WRAP, Q}), 32'(it[8:0]));
                if (it[16:9] != 8'd0) begin
                    check("step_gap", 32'(cyc - last_step), 32'(it[16:9]));
                end
            end
            last_step = cyc;
        end else if (RST && WRAP) begin
            total++;
            bad++;
            $display("FAIL wrap_without_step: q=%0h", Q);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill_v[16];
        logic [7:0] bounce_v[14];
        int hold_bad;
        fill_v = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                   8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        bounce_v = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        // Reset state
        #12;
        check("reset_q", 32'(Q), 32'h00);
        check("reset_step", 32'(STEP), 0);
        check("reset_wrap", 32'(WRAP), 0);
        @(negedge CLK);
        RST = 1'b1;

        // FILL_DRAIN, SPEED=0: full 16-step period, wrap on return to 00
        for (int i = 0; i < 16; i++) begin
            push(fill_v[i], i == 15, (i == 0) ? 8'd0 : 8'd4);
        end
        EN = 1'b1;
        drain(200);

        // BOUNCE: reload to 01 with no step, then 14 steps back to 01
        for (int i = 0; i < 14; i++) begin
            push(bounce_v[i], i == 13, (i == 0) ? 8'd5 : 8'd4);
        end
        MODE = 2'd2;
        @(negedge CLK);
        check("reload_bounce_q", 32'(Q), 32'h01);
        check("reload_bounce_step", 32'(STEP), 0);
        drain(200);

        // CHASE at SPEED=3, drop to SPEED=0 with cnt=20: tick on the next clock
        MODE  = 2'd1;
        SPEED = 2'd3;
        repeat (21) @(negedge CLK);
        check("slow_chase_q", 32'(Q), 32'h01);
        push(8'h02, 1'b0, 8'd22);
        push(8'h04, 1'b0, 8'd4);
        push(8'h08, 1'b0, 8'd4);
        push(8'h10, 1'b0, 8'd4);
        SPEED = 2'd0;
        @(negedge CLK);
        check("speed_drop_step", 32'(STEP), 1);
        drain(200);

        // Freeze at Q=10 with two counts already taken, then resume the remainder
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        hold_bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (Q !== 8'h10 || STEP !== 1'b0) hold_bad++;
        end
        check("freeze_hold_errors", 32'(hold_bad), 0);
        check("freeze_q", 32'(Q), 32'h10);
        push(8'h20, 1'b0, 8'd54);
        push(8'h40, 1'b0, 8'd4);
        push(8'h80, 1'b0, 8'd4);
        push(8'h01, 1'b1, 8'd4);
        EN = 1'b1;
        drain(200);

        // CHASE -> BLINK on the same edge as a tick: reload wins, no step
        push(8'hFF, 1'b0, 8'd8);
        push(8'h00, 1'b1, 8'd4);
        push(8'hFF, 1'b0, 8'd4);
        repeat (3) @(negedge CLK);
        MODE = 2'd3;
        @(negedge CLK);
        check("mode_tick_q", 32'(Q), 32'h00);
        check("mode_tick_step", 32'(STEP), 0);
        check("mode_tick_wrap", 32'(WRAP), 0);
        drain(200);

        // Asynchronous reset mid-run, observed before any clock edge
        check("pre_reset_q", 32'(Q), 32'hFF);
        @(posedge CLK);
        #3;
        RST  = 1'b0;
        MODE = 2'd0;
        #1;
        check("async_reset_q", 32'(Q), 32'h00);
        check("async_reset_step", 32'(STEP), 0);
        check("async_reset_wrap", 32'(WRAP), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
